// File: rtl/acc_alu.sv
// Accumulator ALU: single-cycle logic/arithmetic/shift ops on an accumulator,
// plus a multi-cycle shift-add multiply that stalls the request interface.
module acc_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] data,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] accum,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpNot = 4'b0010;
  localparam logic [3:0] OpXor = 4'b0011;
  localparam logic [3:0] OpAdd = 4'b0100;
  localparam logic [3:0] OpSub = 4'b0101;
  localparam logic [3:0] OpAcc = 4'b0110;
  localparam logic [3:0] OpDat = 4'b0111;
  localparam logic [3:0] OpAdc = 4'b1000;
  localparam logic [3:0] OpSbb = 4'b1001;
  localparam logic [3:0] OpShl = 4'b1010;
  localparam logic [3:0] OpShr = 4'b1011;
  localparam logic [3:0] OpRol = 4'b1100;
  localparam logic [3:0] OpRor = 4'b1101;
  localparam logic [3:0] OpMul = 4'b1110;
  localparam logic [3:0] OpClr = 4'b1111;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   accum_q, accum_d;
  logic [WIDTH-1:0]   alu_out_q, alu_out_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  logic [WIDTH-1:0]   res;
  logic               res_c, res_v, upd_c, upd_v, cin;
  logic [WIDTH:0]     add_w, sub_w;
  logic [2*WIDTH-1:0] prod_step;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign alu_out   = alu_out_q;
  assign accum     = accum_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;

  // Single-cycle result and flag candidates for the presented opcode
  always_comb begin
    cin   = ((opcode == OpAdc) || (opcode == OpSbb)) ? carry_q : 1'b0;
    add_w = {1'b0, accum_q} + {1'b0, data} + {{WIDTH{1'b0}}, cin};
    // Bit WIDTH of the extended difference is the borrow out
    sub_w = {1'b0, accum_q} - {1'b0, data} - {{WIDTH{1'b0}}, cin};
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    upd_c = 1'b0;
    upd_v = 1'b0;
    unique case (opcode)
      OpAnd: res = accum_q & data;
      OpOr:  res = accum_q | data;
      OpNot: res = ~accum_q;
      OpXor: res = accum_q ^ data;
      OpAdd, OpAdc: begin
        res   = add_w[WIDTH-1:0];
        res_c = add_w[WIDTH];
        res_v = (accum_q[WIDTH-1] == data[WIDTH-1]) && (res[WIDTH-1] != accum_q[WIDTH-1]);
        upd_c = 1'b1;
        upd_v = 1'b1;
      end
      OpSub, OpSbb: begin
        res   = sub_w[WIDTH-1:0];
        res_c = sub_w[WIDTH];
        res_v = (accum_q[WIDTH-1] != data[WIDTH-1]) && (res[WIDTH-1] != accum_q[WIDTH-1]);
        upd_c = 1'b1;
        upd_v = 1'b1;
      end
      OpAcc: res = accum_q;
      OpDat: res = data;
      OpShl: begin
        res   = {accum_q[WIDTH-2:0], 1'b0};
        res_c = accum_q[WIDTH-1];
        upd_c = 1'b1;
      end
      OpShr: begin
        res   = {1'b0, accum_q[WIDTH-1:1]};
        res_c = accum_q[0];
        upd_c = 1'b1;
      end
      OpRol: begin
        res   = {accum_q[WIDTH-2:0], accum_q[WIDTH-1]};
        res_c = accum_q[WIDTH-1];
        upd_c = 1'b1;
      end
      OpRor: begin
        res   = {accum_q[0], accum_q[WIDTH-1:1]};
        res_c = accum_q[0];
        upd_c = 1'b1;
      end
      OpMul: res = '0;  // handled by the multiply sequencer
      OpClr: res = '0;
      default: res = '0;
    endcase
  end

  assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

  // Next-state: accept in idle, one shift-add step per cycle while multiplying
  always_comb begin
    state_d     = state_q;
    accum_d     = accum_q;
    alu_out_d   = alu_out_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    mplier_d    = mplier_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (opcode == OpMul) begin
            state_d  = StMul;
            mcand_d  = {{WIDTH{1'b0}}, accum_q};
            mplier_d = data;
            prod_d   = '0;
            cnt_d    = '0;
          end else begin
            accum_d     = res;
            alu_out_d   = res;
            zero_d      = (res == '0);
            out_valid_d = 1'b1;
            if (upd_c) carry_d = res_c;
            if (upd_v) ovf_d = res_v;
          end
        end
      end
      StMul: begin
        prod_d   = prod_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d     = StIdle;
          cnt_d       = '0;
          accum_d     = prod_step[WIDTH-1:0];
          alu_out_d   = prod_step[WIDTH-1:0];
          zero_d      = (prod_step[WIDTH-1:0] == '0);
          carry_d     = |prod_step[2*WIDTH-1:WIDTH];
          ovf_d       = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      accum_q     <= '0;
      alu_out_q   <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      mcand_q     <= '0;
      prod_q      <= '0;
      mplier_q    <= '0;
    end else begin
      state_q     <= state_d;
      accum_q     <= accum_d;
      alu_out_q   <= alu_out_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      prod_q      <= prod_d;
      mplier_q    <= mplier_d;
    end
  end

endmodule

// File: tb/tb_acc_alu.sv
// Randomized self-checking bench for acc_alu against an integer reference model.
module tb_acc_alu;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   opcode = 4'h0;
  logic [W-1:0] data = '0;
  logic         out_valid;
  logic [W-1:0] alu_out;
  logic [W-1:0] accum;
  logic         zero, carry, overflow;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_acc, m_out, m_c, m_v, m_z;

  acc_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .data     (data),
    .out_valid(out_valid),
    .alu_out  (alu_out),
    .accum    (accum),
    .zero     (zero),
    .carry    (carry),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sgn(input int x);
    return (x >= (1 << (W - 1))) ? x - (1 << W) : x;
  endfunction

  function automatic int ovr(input int x);
    return ((x < -(1 << (W - 1))) || (x > (1 << (W - 1)) - 1)) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_out = 0; m_c = 0; m_v = 0; m_z = 0;
  endtask

  task automatic model_apply(input int op, input int d);
    int a, r, s, ci;
    a  = m_acc;
    r  = 0;
    ci = 0;
    case (op)
      0:  r = a & d;
      1:  r = a | d;
      2:  r = (~a) & MASK;
      3:  r = a ^ d;
      4, 8: begin
        ci  = (op == 8) ? m_c : 0;
        s   = a + d + ci;
        r   = s & MASK;
        m_c = (s > MASK) ? 1 : 0;
        m_v = ovr(sgn(a) + sgn(d) + ci);
      end
      5, 9: begin
        ci  = (op == 9) ? m_c : 0;
        s   = a - d - ci;
        r   = s & MASK;
        m_c = (s < 0) ? 1 : 0;
        m_v = ovr(sgn(a) - sgn(d) - ci);
      end
      6:  r = a;
      7:  r = d;
      10: begin r = (a * 2) & MASK; m_c = a / (1 << (W - 1)); end
      11: begin r = a / 2; m_c = a % 2; end
      12: begin r = ((a * 2) & MASK) + a / (1 << (W - 1)); m_c = a / (1 << (W - 1)); end
      13: begin r = a / 2 + (a % 2) * (1 << (W - 1)); m_c = a % 2; end
      14: begin
        s   = a * d;
        r   = s & MASK;
        m_c = (s > MASK) ? 1 : 0;
        m_v = 0;
      end
      default: r = 0;
    endcase
    m_acc = r;
    m_out = r;
    m_z   = (r == 0) ? 1 : 0;
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_accum"}, int'(accum), m_acc);
    check_eq({tag, "_alu_out"}, int'(alu_out), m_out);
    check_eq({tag, "_zero"}, int'(zero), m_z);
    check_eq({tag, "_carry"}, int'(carry), m_c);
    check_eq({tag, "_overflow"}, int'(overflow), m_v);
  endtask

  // Issue one op; with hold set, keep a CLR request pending through a multiply
  task automatic do_op(input int op, input int d, input bit hold);
    check_eq("ready_before_op", int'(in_ready), 1);
    in_valid = 1'b1;
    opcode   = 4'(op);
    data     = W'(d);
    tick();
    model_apply(op, d);
    if (op == 14) begin
      if (hold) begin
        opcode = 4'hF;
        data   = W'($urandom_range(0, MASK));
      end else begin
        in_valid = 1'b0;
      end
      for (int k = 0; k < W; k++) begin
        check_eq("mul_in_ready_low", int'(in_ready), 0);
        check_eq("mul_out_valid_early", int'(out_valid), 0);
        tick();
      end
    end
    in_valid = 1'b0;
    check_eq("out_valid_pulse", int'(out_valid), 1);
    check_eq("ready_after_op", int'(in_ready), 1);
    check_state("op");
  endtask

  task automatic idle_check();
    tick();
    check_eq("out_valid_drop", int'(out_valid), 0);
    check_state("idle");
  endtask

  task automatic reset_dut();
    rst      = 1'b1;
    in_valid = 1'b1;  // reset must override a simultaneous accept
    opcode   = 4'h7;
    data     = W'(8'h55);
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    model_reset();
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_in_ready", int'(in_ready), 1);
    check_state("rst");
  endtask

  initial begin
    model_reset();
    tick();
    reset_dut();

    // Signed overflow into the sign bit
    do_op(7, 'h7F, 0);
    do_op(4, 'h01, 0);
    check_eq("d24_accum", int'(accum), 'h80);
    check_eq("d24_overflow", int'(overflow), 1);
    idle_check();

    // Unsigned wrap, then carry-in consumed
    do_op(7, 'hFF, 0);
    do_op(4, 'h01, 0);
    check_eq("d25_zero", int'(zero), 1);
    check_eq("d25_carry", int'(carry), 1);
    do_op(8, 'h00, 0);
    check_eq("d25_adc", int'(accum), 'h01);

    // Borrow, then carry preserved by a logic op
    do_op(7, 'h00, 0);
    do_op(5, 'h01, 0);
    check_eq("d26_sub", int'(accum), 'hFF);
    do_op(0, 'h0F, 0);
    check_eq("d26_carry_kept", int'(carry), 1);

    // Multiply with a pending request held off
    do_op(7, 'h0C, 0);
    do_op(14, 'h15, 1);
    check_eq("d27_mul", int'(accum), 'hFC);
    idle_check();
    do_op(7, 'h10, 0);
    do_op(14, 'h10, 0);
    check_eq("d27_mul_hi", int'(carry), 1);
    check_eq("d27_mul_zero", int'(zero), 1);

    // Shifts and rotates
    do_op(7, 'h81, 0); do_op(13, 0, 0);
    check_eq("d28_ror", int'(accum), 'hC0);
    do_op(7, 'h81, 0); do_op(11, 0, 0);
    check_eq("d28_shr", int'(accum), 'h40);
    do_op(7, 'h81, 0); do_op(12, 0, 0);
    check_eq("d28_rol", int'(accum), 'h03);

    // Reset three cycles into a multiply aborts it
    do_op(7, 'h33, 0);
    in_valid = 1'b1;
    opcode   = 4'hE;
    data     = W'(8'h07);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check_eq("abort_in_ready", int'(in_ready), 1);
    check_eq("abort_out_valid", int'(out_valid), 0);
    check_state("abort");
    for (int k = 0; k < W + 2; k++) begin
      tick();
      check_eq("abort_no_late_valid", int'(out_valid), 0);
    end
    check_state("abort_after");

    // Random traffic, mostly back-to-back
    for (int i = 0; i < 400; i++) begin
      do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, MASK)),
            bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_check();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/acc_alu.md
ACC_ALU -- requirements
Module: acc_alu

Interface
REQ-001 Parameter: WIDTH, 8, datapath and accumulator width in bits (>=4).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  operation request present.
REQ-005 Port: in_ready  output  1  block can accept an operation; equals (state==IDLE).
REQ-006 Port: opcode  input  4  operation select, sampled on accept.
REQ-007 Port: data  input  WIDTH  operand B, sampled on accept.
REQ-008 Port: out_valid  output  1  one-cycle pulse, result on alu_out/flags is new.
REQ-009 Port: alu_out  output  WIDTH  registered result of last completed operation.
REQ-010 Port: accum  output  WIDTH  accumulator register (operand A).
REQ-011 Port: zero, carry, overflow  output  1 each  registered status flags.

Function
REQ-012 Accept occurs on a rising edge with in_valid && in_ready; otherwise opcode/data ignored, no state change.
REQ-013 Every completed operation writes its result to both accum and alu_out and updates flags per REQ-017..020.
REQ-014 Opcodes: 0000 AND, 0001 OR, 0010 NOT(~accum), 0011 XOR, 0100 ADD, 0101 SUB(accum-data), 0110 ACC(hold), 0111 DAT(load data), 1000 ADC(accum+data+carry), 1001 SBB(accum-data-carry), 1010 SHL, 1011 SHR(logical), 1100 ROL, 1101 ROR, 1110 MUL, 1111 CLR(result 0). Shifts/rotates by one bit of accum; data ignored.
REQ-015 All opcodes except MUL: single-cycle; accepted at edge N, out_valid high for exactly the cycle after edge N; in_ready stays 1; back-to-back accepts every cycle permitted, each using accum updated by the previous one.
REQ-016 MUL: FSM states IDLE, MUL. Accept at edge N -> state MUL, capture accum and data, step counter 0. One shift-add step per edge; at edge N+WIDTH write low WIDTH bits of product, state IDLE, out_valid high in the following cycle. in_ready low from edge N to edge N+WIDTH; in_valid during MUL ignored.
REQ-017 zero: set to (result==0) for every opcode.
REQ-018 carry: ADD/ADC carry-out; SUB/SBB borrow (1 when unsigned accum < data+cin); SHL/ROL old accum[WIDTH-1]; SHR/ROR old accum[0]; MUL 1 iff high product half nonzero; all other opcodes unchanged.
REQ-019 overflow: ADD/ADC 1 iff operands same sign and result sign differs; SUB/SBB 1 iff operand signs differ and result sign differs from accum; MUL 0; all other opcodes unchanged.
REQ-020 Arithmetic is modulo 2^WIDTH; ROL/ROR wrap the shifted-out bit into the vacated end; SHL/SHR fill with 0.
REQ-021 out_valid has no backpressure; consumer must sample it in its pulse cycle.

Reset
REQ-022 rst high at an edge: accum=0, alu_out=0, zero=0, carry=0, overflow=0, out_valid=0, state=IDLE, counter=0; overrides any simultaneous accept.
REQ-023 rst during MUL aborts it: no out_valid, no result write; in_ready=1 the cycle after the reset edge.

Verification (WIDTH=8)
REQ-024 Reset; DAT 0x7F; ADD 0x01 -> accum 0x80, overflow=1, carry=0, zero=0, one out_valid pulse per op.
REQ-025 DAT 0xFF; ADD 0x01 -> accum 0x00, carry=1, zero=1, overflow=0; then ADC 0x00 -> accum 0x01, carry=0.
REQ-026 DAT 0x00; SUB 0x01 -> accum 0xFF, carry=1, overflow=0; then AND 0x0F -> 0x0F, carry still 1.
REQ-027 DAT 0x0C; MUL 0x15 with in_valid held high -> in_ready low 8 cycles, accum 0xFC, carry=0, out_valid exactly 8 cycles after accept, queued op accepted only after; DAT 0x10; MUL 0x10 -> accum 0x00, carry=1, zero=1.
REQ-028 DAT 0x81; ROR -> 0xC0, carry=1; DAT 0x81; SHR -> 0x40, carry=1; DAT 0x81; ROL -> 0x03, carry=1.
REQ-029 Start MUL, assert rst 3 cycles later -> all outputs at reset values, no out_valid, in_ready=1 next cycle.
